pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised program-counter generator for the RV32I core. It holds the PC register and selects the next PC from sequential (+4), register-indirect (JALR), immediate-target (branch/JAL) and trap sources. A redirect that arrives during a stall is buffered in a pending register and applied when the stall releases. Misaligned redirect targets are detected and forced to the trap vector. It sits in front of instruction memory and is driven by the control unit and branch/ALU path.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_VECTOR, 32'h0000_0000, PC value after reset.
TRAP_VECTOR, 32'h0000_0100, PC loaded on a trap request or on a misaligned redirect.
ALIGN_BITS, 2, number of low target bits that must be zero (2 = word-aligned fetch).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
stall  in  1  1 = hold the PC this cycle.
pc_src  in  2  00 = +4, 01 = pc_next (JALR), 10 = imm_address (branch/JAL), 11 = trap.
pc_next  in  XLEN  register-indirect target.
imm_address  in  XLEN  immediate target.
pc_out  out  XLEN  current fetch PC (registered).
pc_plus4  out  XLEN  pc_out + 4, combinational, modulo 2^XLEN.
pc_valid  out  1  1 = pc_out is a valid fetch address.
redirect_pending  out  1  1 = a buffered redirect is waiting for the stall to release.
misalign_trap  out  1  one-cycle pulse when a misaligned redirect is replaced by TRAP_VECTOR.
bad_addr  out  XLEN  last misaligned target; holds its value until the next misalignment.

Behaviour:
- Reset (async, any state): pc_out=RESET_VECTOR; pc_valid=0; redirect_pending=0; misalign_trap=0; bad_addr=0; pending register=0; state=BOOT.
- States: BOOT, RUN, HOLD.
- BOOT: one cycle only; next state is RUN; pc_valid becomes 1; pc_out stays RESET_VECTOR, so the first fetch is at RESET_VECTOR. Inputs are ignored in BOOT.
- Target selection: 00 gives pc_out+4; 01 gives pc_next; 10 gives imm_address; 11 gives TRAP_VECTOR.
- Alignment check:
  - Applies only to source 01, 10 and to the pending target.
  - If target[ALIGN_BITS-1:0] != 0: pc_out <= TRAP_VECTOR, misalign_trap=1 for exactly one cycle, bad_addr <= target.
  - +4 and trap sources are never checked.
- RUN, stall=0: pc_out <= selected target, with the alignment check. Latency is one cycle, input to pc_out.
- RUN, stall=1:
  - pc_src=00: pc_out holds.
  - pc_src=01 or 10: pending <= target (unchecked), redirect_pending=1, go to HOLD; pc_out holds.
- HOLD, stall=1: pc_out holds. A new 01/10 request overwrites pending (newest wins). A 00 request leaves pending unchanged.
- HOLD, stall=0:
  - pc_src=00: pc_out <= pending, with the alignment check.
  - pc_src=01/10 in the same cycle: the new target wins and pending is discarded.
  - In both cases: redirect_pending=0, go to RUN.
- Trap (pc_src=11): highest priority, overrides stall in any state except BOOT. pc_out <= TRAP_VECTOR next cycle; pending is cleared; redirect_pending=0; state goes to RUN.
- Wrap-around: pc_out=2^XLEN-4 with +4 gives pc_out=0, with no flag.
- misalign_trap is 0 in every cycle without a new misalignment event.
- Reset asserted mid-HOLD discards pending immediately, asynchronously.

Test Plan:
1. Reset then release; stall=0, pc_src=00 -> pc_out: 0 (pc_valid=0), 0 (pc_valid=1), 4, 8, C; pc_plus4 always equals pc_out+4.
2. In RUN at pc_out=0x10, pc_src=10, imm_address=0x200, stall=0 -> next pc_out=0x200, misalign_trap=0.
3. stall=1 for 3 cycles with pc_src=01, pc_next=0x80 in the first cycle, then 00 -> redirect_pending=1, pc_out held. On release: pc_out=0x80, redirect_pending=0. Repeat with a second redirect 0x90 during the stall -> pc_out=0x90.
4. pc_src=01, pc_next=0x102 -> pc_out=0x100 (TRAP_VECTOR), misalign_trap high for exactly 1 cycle, bad_addr=0x102. Repeat via the pending path -> same result.
5. In HOLD with pending 0x80, assert pc_src=11 while stall=1 -> pc_out=0x100 next cycle, redirect_pending=0. On stall release, pc_out=0x104 (pending is not applied).
6. pc_out=0xFFFF_FFFC with +4 -> pc_out=0. Assert rst asynchronously mid-HOLD -> pc_out=0 and redirect_pending=0 before the next edge.

Source files
------------

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program-counter generator for the RV32I core.
//
// Holds the fetch PC and picks the next one from four sources: sequential
// (+4), register-indirect (JALR), immediate target (branch/JAL) and the trap
// vector. A JALR or branch redirect that arrives while the pipeline is
// stalled is parked in a pending register. It is applied when the stall
// releases. Redirect targets that are not aligned are replaced by the trap
// vector, and the offending address is captured in bad_addr.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   stall            1 = hold the PC this cycle
//   pc_src           00 = +4, 01 = pc_next, 10 = imm_address, 11 = trap
//   pc_next          register-indirect target
//   imm_address      immediate target
//   pc_out           current fetch PC (registered)
//   pc_plus4         pc_out + 4 (combinational, wraps modulo 2^XLEN)
//   pc_valid         pc_out is a valid fetch address
//   redirect_pending a buffered redirect waits for the stall to release
//   misalign_trap    one-cycle pulse when a misaligned redirect is trapped
//   bad_addr         last misaligned target, held until the next one
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_next,
    input  logic [XLEN-1:0] imm_address,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            redirect_pending,
    output logic            misalign_trap,
    output logic [XLEN-1:0] bad_addr
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_JALR = 2'b01;
    localparam logic [1:0] SRC_IMM  = 2'b10;
    localparam logic [1:0] SRC_TRAP = 2'b11;

    // Low target bits that must be zero for a fetch address to be legal.
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;

    // A redirect that must go through the alignment check this cycle.
    logic            apply_redirect;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] new_target;
    logic            is_redirect;

    assign new_target  = (pc_src == SRC_JALR) ? pc_next : imm_address;
    assign is_redirect = (pc_src == SRC_JALR) || (pc_src == SRC_IMM);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statements can leave one unassigned and infer a latch.
        state_d         = state_q;
        pc_d            = pc_q;
        pending_d       = pending_q;
        bad_d           = bad_q;
        valid_d         = valid_q;
        misalign_d      = 1'b0;
        apply_redirect  = 1'b0;
        redirect_target = new_target;

        unique case (state_q)
            BOOT: begin
                // The first fetch goes to RESET_VECTOR. Inputs are ignored here.
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN, HOLD: begin
                if (pc_src == SRC_TRAP) begin
                    // A trap wins over stall and over any parked redirect.
                    pc_d      = TRAP_VECTOR;
                    pending_d = '0;
                    state_d   = RUN;
                end else if (stall) begin
                    // The PC holds. The newest redirect overwrites the parked one.
                    if (is_redirect) begin
                        pending_d = new_target;
                        state_d   = HOLD;
                    end
                end else if (is_redirect) begin
                    // A fresh redirect beats and discards any parked one.
                    apply_redirect = 1'b1;
                    pending_d      = '0;
                    state_d        = RUN;
                end else if (state_q == HOLD) begin
                    apply_redirect  = 1'b1;
                    redirect_target = pending_q;
                    pending_d       = '0;
                    state_d         = RUN;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            default: state_d = BOOT;
        endcase

        if (apply_redirect) begin
            if ((redirect_target & ALIGN_MASK) != '0) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
                bad_d      = redirect_target;
            end else begin
                pc_d = redirect_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the pending register is reset along with the other state, so
        // a reset in HOLD cannot leave a stale target behind.
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pending_q  <= '0;
            bad_q      <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // values from before the clock edge, whatever order they are written in.
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            bad_q      <= bad_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_out           = pc_q;
    assign pc_plus4         = pc_q + XLEN'(4);
    assign pc_valid         = valid_q;
    assign redirect_pending = (state_q == HOLD);
    assign misalign_trap    = misalign_q;
    assign bad_addr         = bad_q;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed self-checking bench for pc_gen.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] pc_next;
    logic [31:0] imm_address;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        redirect_pending;
    logic        misalign_trap;
    logic [31:0] bad_addr;

    int tests = 0;
    int fails = 0;

    pc_gen dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .pc_src           (pc_src),
        .pc_next          (pc_next),
        .imm_address      (imm_address),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .pc_valid         (pc_valid),
        .redirect_pending (redirect_pending),
        .misalign_trap    (misalign_trap),
        .bad_addr         (bad_addr)
    );

    always #5 clk = ~clk;

    // Apply inputs, then advance one rising edge and settle 1 ns past it.
    task automatic step(input logic s, input logic [1:0] src,
                        input logic [31:0] nxt, input logic [31:0] imm);
        stall       = s;
        pc_src      = src;
        pc_next     = nxt;
        imm_address = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; pc_src = 2'b00; pc_next = '0; imm_address = '0;
        @(posedge clk); #1;
        tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h exp %h", pc_out, 32'h0); end
        tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", pc_valid); end
        tests++; if (redirect_pending !== 1'b0) begin fails++; $display("FAIL rst_pend: got %b exp 0", redirect_pending); end
        tests++; if (misalign_trap !== 1'b0) begin fails++; $display("FAIL rst_mis: got %b exp 0", misalign_trap); end
        tests++; if (bad_addr !== 32'h0) begin fails++; $display("FAIL rst_bad: got %h exp 0", bad_addr); end
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        // Still in BOOT: the PC sits at the reset vector and is not yet valid.
        tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL boot_valid: got %b exp 0", pc_valid); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, '0, '0);
            tests++; if (pc_out !== exp_pc[i]) begin fails++; $display("FAIL seq_pc%0d: got %h exp %h", i, pc_out, exp_pc[i]); end
            tests++; if (pc_plus4 !== exp_pc[i] + 32'h4) begin fails++; $display("FAIL seq_p4_%0d: got %h exp %h", i, pc_plus4, exp_pc[i] + 32'h4); end
            tests++; if (pc_valid !== 1'b1) begin fails++; $display("FAIL seq_valid%0d: got %b exp 1", i, pc_valid); end
        end
    endtask

    task automatic test_branch;
        step(1'b0, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h10) begin fails++; $display("FAIL br_pre: got %h exp %h", pc_out, 32'h10); end
        step(1'b0, 2'b10, '0, 32'h200);
        tests++; if (pc_out !== 32'h200) begin fails++; $display("FAIL br_pc: got %h exp %h", pc_out, 32'h200); end
        tests++; if (misalign_trap !== 1'b0) begin fails++; $display("FAIL br_mis: got %b exp 0", misalign_trap); end
    endtask

    task automatic test_stall_redirect;
        step(1'b1, 2'b01, 32'h80, '0);
        tests++; if (redirect_pending !== 1'b1) begin fails++; $display("FAIL st_pend: got %b exp 1", redirect_pending); end
        tests++; if (pc_out !== 32'h200) begin fails++; $display("FAIL st_hold0: got %h exp %h", pc_out, 32'h200); end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'b00, '0, '0);
            tests++; if (pc_out !== 32'h200) begin fails++; $display("FAIL st_hold%0d: got %h exp %h", i + 1, pc_out, 32'h200); end
            tests++; if (redirect_pending !== 1'b1) begin fails++; $display("FAIL st_pend%0d: got %b exp 1", i + 1, redirect_pending); end
        end
        step(1'b0, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h80) begin fails++; $display("FAIL st_rel: got %h exp %h", pc_out, 32'h80); end
        tests++; if (redirect_pending !== 1'b0) begin fails++; $display("FAIL st_rel_pend: got %b exp 0", redirect_pending); end
        // The newest redirect during a stall replaces the older one.
        step(1'b1, 2'b01, 32'h80, '0);
        step(1'b1, 2'b10, '0, 32'h90);
        step(1'b1, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h80) begin fails++; $display("FAIL nw_hold: got %h exp %h", pc_out, 32'h80); end
        step(1'b0, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h90) begin fails++; $display("FAIL nw_rel: got %h exp %h", pc_out, 32'h90); end
        // A redirect in the release cycle beats the parked target.
        step(1'b1, 2'b01, 32'h80, '0);
        step(1'b0, 2'b10, '0, 32'h300);
        tests++; if (pc_out !== 32'h300) begin fails++; $display("FAIL ov_pc: got %h exp %h", pc_out, 32'h300); end
        tests++; if (redirect_pending !== 1'b0) begin fails++; $display("FAIL ov_pend: got %b exp 0", redirect_pending); end
        step(1'b0, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h304) begin fails++; $display("FAIL ov_next: got %h exp %h", pc_out, 32'h304); end
    endtask

    task automatic test_misalign;
        step(1'b0, 2'b01, 32'h102, '0);
        tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL mis_pc: got %h exp %h", pc_out, 32'h100); end
        tests++; if (misalign_trap !== 1'b1) begin fails++; $display("FAIL mis_pulse: got %b exp 1", misalign_trap); end
        tests++; if (bad_addr !== 32'h102) begin fails++; $display("FAIL mis_bad: got %h exp %h", bad_addr, 32'h102); end
        step(1'b0, 2'b00, '0, '0);
        tests++; if (misalign_trap !== 1'b0) begin fails++; $display("FAIL mis_clr: got %b exp 0", misalign_trap); end
        tests++; if (pc_out !== 32'h104) begin fails++; $display("FAIL mis_next: got %h exp %h", pc_out, 32'h104); end
        tests++; if (bad_addr !== 32'h102) begin fails++; $display("FAIL mis_badhold: got %h exp %h", bad_addr, 32'h102); end
        // Same case again, this time through the pending path.
        step(1'b1, 2'b01, 32'h106, '0);
        tests++; if (misalign_trap !== 1'b0) begin fails++; $display("FAIL mp_nochk: got %b exp 0", misalign_trap); end
        step(1'b0, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL mp_pc: got %h exp %h", pc_out, 32'h100); end
        tests++; if (misalign_trap !== 1'b1) begin fails++; $display("FAIL mp_pulse: got %b exp 1", misalign_trap); end
        tests++; if (bad_addr !== 32'h106) begin fails++; $display("FAIL mp_bad: got %h exp %h", bad_addr, 32'h106); end
        step(1'b0, 2'b00, '0, '0);
        tests++; if (misalign_trap !== 1'b0) begin fails++; $display("FAIL mp_clr: got %b exp 0", misalign_trap); end
    endtask

    task automatic test_trap_in_hold;
        step(1'b0, 2'b10, '0, 32'h40);
        step(1'b1, 2'b01, 32'h80, '0);
        tests++; if (redirect_pending !== 1'b1) begin fails++; $display("FAIL tr_pend: got %b exp 1", redirect_pending); end
        step(1'b1, 2'b11, '0, '0);
        tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL tr_pc: got %h exp %h", pc_out, 32'h100); end
        tests++; if (redirect_pending !== 1'b0) begin fails++; $display("FAIL tr_pclr: got %b exp 0", redirect_pending); end
        step(1'b1, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL tr_hold: got %h exp %h", pc_out, 32'h100); end
        step(1'b0, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h104) begin fails++; $display("FAIL tr_rel: got %h exp %h", pc_out, 32'h104); end
    endtask

    task automatic test_wrap_and_async_reset;
        step(1'b0, 2'b10, '0, 32'hFFFF_FFFC);
        tests++; if (pc_plus4 !== 32'h0) begin fails++; $display("FAIL wr_p4: got %h exp 0", pc_plus4); end
        step(1'b0, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL wr_pc: got %h exp 0", pc_out); end
        tests++; if (misalign_trap !== 1'b0) begin fails++; $display("FAIL wr_flag: got %b exp 0", misalign_trap); end
        step(1'b0, 2'b00, '0, '0);
        step(1'b1, 2'b01, 32'h80, '0);
        tests++; if (pc_out !== 32'h4 || redirect_pending !== 1'b1) begin
            fails++; $display("FAIL ar_pre: got pc %h pend %b exp pc 4 pend 1", pc_out, redirect_pending);
        end
        // Assert reset between edges; outputs must clear with no clock.
        rst = 1'b1;
        #2;
        tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL ar_pc: got %h exp 0", pc_out); end
        tests++; if (redirect_pending !== 1'b0) begin fails++; $display("FAIL ar_pend: got %b exp 0", redirect_pending); end
        tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b exp 0", pc_valid); end
        // After release, BOOT, then RUN at 0 and 4. The old pending target is gone.
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 2'b00, '0, '0);
        step(1'b0, 2'b00, '0, '0);
        tests++; if (pc_out !== 32'h4) begin fails++; $display("FAIL ar_after: got %h exp %h", pc_out, 32'h4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_redirect();
        test_misalign();
        test_trap_in_hold();
        test_wrap_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
